aclk_key_entry: RTL and testbench
=================================

Name: aclk_key_entry

Overview:
- Keypad entry controller upstream of the time counter; supplies its `load_new_c` and `new_current_time_*` inputs.
- Collects up to 4 BCD digits into a shift buffer, shown as HH:MM.
- On a TIME or ALARM command it range-checks the buffer, then pulses `load_new_c` or `load_new_a` for one cycle.
- Abandons an entry after a programmable idle timeout counted in `one_second` ticks.

Parameters:
- TIMEOUT_SECS, 10, number of `one_second` ticks with no accepted key before the entry is abandoned (1..255).
- TO_W, 8, timeout counter width; must hold TIMEOUT_SECS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- one_second  input  1  one-cycle strobe once per second, used only for the timeout.
- key_digit  input  4  digit value, sampled when `digit_strobe`=1.
- digit_strobe  input  1  one-cycle strobe: `key_digit` is valid.
- time_button  input  1  one-cycle strobe: load buffer as current time.
- alarm_button  input  1  one-cycle strobe: load buffer as alarm time.
- clear_button  input  1  one-cycle strobe: abandon entry.
- key_buffer_ms_hr  output  4  buffer digit H tens.
- key_buffer_ls_hr  output  4  buffer digit H units.
- key_buffer_ms_min  output  4  buffer digit M tens.
- key_buffer_ls_min  output  4  buffer digit M units.
- load_new_c  output  1  one-cycle pulse: counter loads buffer.
- load_new_a  output  1  one-cycle pulse: alarm register loads buffer.
- show_new_time  output  1  high while an entry is in progress (display shows buffer).
- entry_error  output  1  one-cycle pulse: command rejected, buffer out of range.

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE; all buffer digits 0; digit count 0; timeout count 0.
  - `load_new_c`, `load_new_a`, `show_new_time`, `entry_error` all 0.
- FSM states: IDLE, ENTRY, LOAD.
- Event priority within one cycle: `clear_button` > `time_button` > `alarm_button` > `digit_strobe`. Lower-priority strobes in the same cycle are dropped.
- Digit acceptance:
  - Accepted only if `key_digit`<=9; digits 10..15 are ignored entirely (no shift, no timeout restart).
  - Accepted digit shifts left: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key_digit.
  - Digit count saturates at 4; further digits keep shifting and the oldest digit is lost.
- IDLE:
  - Accepted digit -> ENTRY. Buffer is first zeroed, then the digit is shifted in (result 00:0d). Count=1.
  - `time_button`, `alarm_button`, `clear_button` and `one_second` are ignored.
- ENTRY:
  - `show_new_time`=1.
  - Accepted digit: shift, count+1 (saturating), timeout count <= 0.
  - `one_second`: timeout count +1. When it reaches TIMEOUT_SECS -> IDLE, buffer and count cleared. If an accepted digit coincides, the digit wins and resets the count.
  - `clear_button` -> IDLE, buffer cleared.
  - `time_button`/`alarm_button`: validate the buffer. Fewer than 4 digits is legal; leading zeros come from the shift.
    - Valid when ms_hr<=2, ls_hr<=9, (ms_hr<2 or ls_hr<=3), ms_min<=5, ls_min<=9.
    - Valid -> LOAD, remembering the target (C or A).
    - Invalid -> `entry_error`=1 on the next cycle, FSM -> IDLE, buffer cleared.
- LOAD (exactly one cycle):
  - `load_new_c` or `load_new_a` = 1 per target; buffer holds the entered value during this cycle; `show_new_time`=1.
  - Next cycle -> IDLE; buffer cleared; pulse deasserts.
  - All inputs are ignored in LOAD.
- Latency: command strobe at edge N -> load pulse or `entry_error` high for the cycle after edge N+1.
- All outputs are registered.
- Mid-entry reset: immediate return to reset values; no pulse is emitted.
- The buffer is 00:00 whenever the FSM is IDLE.

Test Plan:
1. Reset released; digits 1,2,3,4 then `time_button` -> buffer 12:34 during LOAD; `load_new_c`=1 for exactly 1 cycle, `load_new_a`=0; then IDLE with buffer 00:00.
2. Digits 2,4,0,0 then `alarm_button` -> `entry_error` pulse 1 cycle, no load pulse, `show_new_time` drops. Repeat with 2,3,5,9 -> `load_new_a` pulse, buffer 23:59.
3. Digits 7,4,5 then `time_button` -> buffer 07:45, `load_new_c` pulse. Then 1,2,3,4,5 -> buffer 23:45, count saturated at 4.
4. Digit 5, then TIMEOUT_SECS `one_second` strobes -> IDLE after the 10th. Variant: digit on the 9th tick -> timeout restarts; 10 more ticks needed.
5. `time_button`+`clear_button` same cycle in ENTRY -> clear wins, no load. Digit 12 strobed -> ignored. `time_button` in IDLE -> no pulse.
6. reset=0 asserted mid-ENTRY and in the LOAD cycle -> outputs 0 immediately; no pulse after release.

Source files
------------

// File: rtl/aclk_key_entry.sv
// Keypad entry controller: shifts BCD digits into an HH:MM buffer, range-checks it on
// a TIME/ALARM command and pulses the matching load strobe, abandoning stale entries.
module aclk_key_entry #(
  parameter int TIMEOUT_SECS = 10,
  parameter int TO_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key_digit,
  input  logic       digit_strobe,
  input  logic       time_button,
  input  logic       alarm_button,
  input  logic       clear_button,
  output logic [3:0] key_buffer_ms_hr,
  output logic [3:0] key_buffer_ls_hr,
  output logic [3:0] key_buffer_ms_min,
  output logic [3:0] key_buffer_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       entry_error
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD} state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_SECS);

  state_t          state_q, state_d;
  logic [15:0]     buf_q, buf_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            load_c_q, load_c_d;
  logic            load_a_q, load_a_d;
  logic            err_q, err_d;
  logic            show_q, show_d;
  logic            dig_ok, cmd;

  function automatic logic valid_time(input logic [15:0] b);
    logic [3:0] mh, lh, mm, lm;
    mh = b[15:12];
    lh = b[11:8];
    mm = b[7:4];
    lm = b[3:0];
    return (mh <= 4'd2) && (lh <= 4'd9) && ((mh < 4'd2) || (lh <= 4'd3)) &&
           (mm <= 4'd5) && (lm <= 4'd9);
  endfunction

  assign dig_ok = digit_strobe && (key_digit <= 4'd9);
  assign cmd    = time_button || alarm_button;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    load_c_d = 1'b0;
    load_a_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Any command strobe outranks a digit in the same cycle, even though commands do nothing here.
        if (!(clear_button || cmd) && dig_ok) begin
          state_d = ENTRY;
          buf_d   = {12'h000, key_digit};
          cnt_d   = 3'd1;
          to_d    = '0;
        end
      end
      ENTRY: begin
        if (clear_button) begin
          state_d = IDLE;
          buf_d   = '0;
          cnt_d   = '0;
          to_d    = '0;
        end else if (cmd) begin
          to_d = '0;
          if (valid_time(buf_q)) begin
            state_d  = LOAD;
            load_c_d = time_button;
            load_a_d = !time_button;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
          end
        end else if (dig_ok) begin
          buf_d = {buf_q[11:0], key_digit};
          cnt_d = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
          to_d  = '0;
        end else if (one_second) begin
          if (to_q + 1'b1 == TO_LIM) begin
            state_d = IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            to_d    = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
        buf_d   = '0;
        cnt_d   = '0;
        to_d    = '0;
      end
      default: begin
        state_d = IDLE;
        buf_d   = '0;
        cnt_d   = '0;
        to_d    = '0;
      end
    endcase
    show_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      load_c_q <= 1'b0;
      load_a_q <= 1'b0;
      err_q    <= 1'b0;
      show_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      load_c_q <= load_c_d;
      load_a_q <= load_a_d;
      err_q    <= err_d;
      show_q   <= show_d;
    end
  end

  assign key_buffer_ms_hr  = buf_q[15:12];
  assign key_buffer_ls_hr  = buf_q[11:8];
  assign key_buffer_ms_min = buf_q[7:4];
  assign key_buffer_ls_min = buf_q[3:0];
  assign load_new_c        = load_c_q;
  assign load_new_a        = load_a_q;
  assign show_new_time     = show_q;
  assign entry_error       = err_q;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Bench for aclk_key_entry: decimal-value reference model compared every cycle,
// directed scenarios with literal expectations, then randomized keypad traffic.
module tb_aclk_key_entry;
  localparam int TIMEOUT_SECS = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       digit_strobe = 1'b0;
  logic       time_button = 1'b0;
  logic       alarm_button = 1'b0;
  logic       clear_button = 1'b0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, show_new_time, entry_error;

  int n_cmp = 0;
  int n_bad = 0;

  aclk_key_entry #(.TIMEOUT_SECS(TIMEOUT_SECS), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .one_second(one_second), .key_digit(key_digit),
    .digit_strobe(digit_strobe), .time_button(time_button), .alarm_button(alarm_button),
    .clear_button(clear_button), .key_buffer_ms_hr(ms_hr), .key_buffer_ls_hr(ls_hr),
    .key_buffer_ms_min(ms_min), .key_buffer_ls_min(ls_min), .load_new_c(load_new_c),
    .load_new_a(load_new_a), .show_new_time(show_new_time), .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  // Reference model: the buffer is a decimal number 0..9999 read as HHMM.
  int m_val = 0;
  int m_to = 0;
  int m_load = 0;  // 0 none, 1 counter, 2 alarm
  bit m_active = 0;
  bit m_err = 0;

  function automatic bit valid_hhmm(input int v);
    return ((v / 100) <= 23) && ((v % 100) <= 59);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_val = 0; m_to = 0; m_load = 0; m_active = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (m_load != 0) begin
        m_load = 0; m_val = 0; m_active = 0; m_to = 0;
      end else if (!m_active) begin
        if (!(clear_button || time_button || alarm_button) && digit_strobe && key_digit <= 9) begin
          m_active = 1; m_val = int'(key_digit); m_to = 0;
        end
      end else if (clear_button) begin
        m_active = 0; m_val = 0; m_to = 0;
      end else if (time_button || alarm_button) begin
        m_active = 0; m_to = 0;
        if (valid_hhmm(m_val)) m_load = time_button ? 1 : 2;
        else begin m_err = 1; m_val = 0; end
      end else if (digit_strobe && key_digit <= 9) begin
        m_val = (m_val * 10 + int'(key_digit)) % 10000; m_to = 0;
      end else if (one_second) begin
        m_to++;
        if (m_to == TIMEOUT_SECS) begin m_active = 0; m_val = 0; m_to = 0; end
      end
    end
  end

  function automatic logic [19:0] exp_vec();
    logic [15:0] b;
    b = {4'(m_val / 1000), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10), 4'(m_val % 10)};
    return {b, m_load == 1, m_load == 2, m_active || (m_load != 0), m_err};
  endfunction

  logic [19:0] dut_vec;
  assign dut_vec = {ms_hr, ls_hr, ms_min, ls_min, load_new_c, load_new_a, show_new_time, entry_error};

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (buf,c,a,show,err) at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) if (reset) check("model", dut_vec, exp_vec());

  task automatic drive(input logic [3:0] d, input bit ds, input bit tb, input bit ab,
                       input bit cb, input bit os);
    @(negedge clk);
    key_digit = d; digit_strobe = ds; time_button = tb;
    alarm_button = ab; clear_button = cb; one_second = os;
    @(negedge clk);
    digit_strobe = 0; time_button = 0; alarm_button = 0; clear_button = 0; one_second = 0;
  endtask

  task automatic key(input logic [3:0] d);
    drive(d, 1, 0, 0, 0, 0);
  endtask

  task automatic keys4(input logic [15:0] k);
    for (int i = 3; i >= 0; i--) key(k[i*4 +: 4]);
  endtask

  initial begin
    #12;
    check("reset_state", dut_vec, 20'h0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_release", dut_vec, 20'h0);

    // 1: 12:34 loaded as current time
    keys4(16'h1234);
    drive(0, 0, 1, 0, 0, 0);
    check("t1_load_c", dut_vec, {16'h1234, 4'b1010});
    check("t1_model_pin", exp_vec(), {16'h1234, 4'b1010});
    @(negedge clk);
    check("t1_idle", dut_vec, 20'h0);

    // 2: 24:00 rejected, 23:59 loaded as alarm, 19:60 rejected
    keys4(16'h2400);
    drive(0, 0, 0, 1, 0, 0);
    check("t2_err", dut_vec, {16'h0000, 4'b0001});
    check("t2_model_pin", exp_vec(), {16'h0000, 4'b0001});
    @(negedge clk);
    check("t2_err_gone", dut_vec, 20'h0);
    keys4(16'h2359);
    drive(0, 0, 0, 1, 0, 0);
    check("t2_load_a", dut_vec, {16'h2359, 4'b0110});
    keys4(16'h1960);
    drive(0, 0, 1, 0, 0, 0);
    check("t2_min_err", dut_vec, {16'h0000, 4'b0001});

    // 3: short entry gets leading zero; overflow drops oldest digit
    key(7); key(4); key(5);
    drive(0, 0, 1, 0, 0, 0);
    check("t3_load_745", dut_vec, {16'h0745, 4'b1010});
    key(1); keys4(16'h2345);
    check("t3_shift", dut_vec, {16'h2345, 4'b0010});
    drive(0, 0, 0, 0, 1, 0);
    check("t3_clear", dut_vec, 20'h0);

    // 4: timeout, and a digit on the 9th tick restarting it
    key(5);
    for (int i = 0; i < TIMEOUT_SECS - 1; i++) drive(0, 0, 0, 0, 0, 1);
    check("t4_before_to", dut_vec, {16'h0005, 4'b0010});
    drive(0, 0, 0, 0, 0, 1);
    check("t4_timeout", dut_vec, 20'h0);
    key(5);
    for (int i = 0; i < TIMEOUT_SECS - 2; i++) drive(0, 0, 0, 0, 0, 1);
    drive(3, 1, 0, 0, 0, 1);
    for (int i = 0; i < TIMEOUT_SECS - 1; i++) drive(0, 0, 0, 0, 0, 1);
    check("t4_restarted", dut_vec, {16'h0053, 4'b0010});
    drive(0, 0, 0, 0, 0, 1);
    check("t4_timeout2", dut_vec, 20'h0);

    // 5: clear beats time, digit 12 ignored, time in IDLE ignored
    key(1);
    drive(0, 0, 1, 0, 1, 0);
    check("t5_clear_wins", dut_vec, 20'h0);
    key(2); key(12);
    check("t5_bad_digit", dut_vec, {16'h0002, 4'b0010});
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    check("t5_idle_time", dut_vec, 20'h0);

    // 6: reset mid-entry and during the load cycle
    key(4); key(2);
    #2 reset = 1'b0;
    #1 check("t6_rst_entry", dut_vec, 20'h0);
    @(negedge clk); reset = 1'b1;
    keys4(16'h1200);
    drive(0, 0, 1, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check("t6_rst_load", dut_vec, 20'h0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("t6_no_pulse", dut_vec, 20'h0);

    // Randomized keypad traffic, checked every cycle by the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      key_digit    = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      digit_strobe = (r < 50) || (r >= 97);
      time_button  = (r >= 50 && r < 55) || (r == 99);
      alarm_button = (r >= 55 && r < 59) || (r == 98);
      clear_button = (r == 59) || (r == 97);
      one_second   = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    digit_strobe = 0; time_button = 0; alarm_button = 0; clear_button = 0; one_second = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
